// File: rtl/fc_func_if.sv
// fc_func port bundle: func-start handshake, OBUF read port and next-layer stream.
// master = the function unit, slave = control FSM / OBUF / next-layer side.
interface fc_func_if #(
    parameter int DATA_SIZE      = 8,
    parameter int XBAR_SIZE      = 256,
    parameter int OBUF_DATA_SIZE = 2*DATA_SIZE+$clog2(XBAR_SIZE),
    parameter int NUM_CHANNELS   = 1,
    parameter int V_CIM_TILES    = 2,
    parameter int FIFO_LENGTH    = XBAR_SIZE/DATA_SIZE/NUM_CHANNELS
);
    localparam int AW = $clog2(FIFO_LENGTH);
    localparam int IW = V_CIM_TILES*NUM_CHANNELS*OBUF_DATA_SIZE;
    localparam int OW = NUM_CHANNELS*DATA_SIZE;

    logic          i_start;
    logic          o_ready;
    logic [AW-1:0] o_obuf_addr;
    logic [IW-1:0] i_obuf_data;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          i_next_busy;
    logic          o_next_start;

    modport master (
        input  i_start, i_obuf_data, i_next_busy,
        output o_ready, o_obuf_addr, o_data, o_valid, o_next_start
    );

    modport slave (
        output i_start, i_obuf_data, i_next_busy,
        input  o_ready, o_obuf_addr, o_data, o_valid, o_next_start
    );
endinterface

// File: rtl/fc_func.sv
// FC layer function unit: sums stacked-tile partials, requantises, saturates.
// Define FC_FUNC_RELU_EN for unsigned ReLU output; default is signed saturation.
module fc_func #(
    parameter int DATA_SIZE      = 8,
    parameter int XBAR_SIZE      = 256,
    parameter int OBUF_DATA_SIZE = 2*DATA_SIZE+$clog2(XBAR_SIZE),
    parameter int NUM_CHANNELS   = 1,
    parameter int V_CIM_TILES    = 2,
    parameter int FIFO_LENGTH    = XBAR_SIZE/DATA_SIZE/NUM_CHANNELS,
    parameter int SHIFT          = 8
) (
    input  logic       clk,
    input  logic       rst,
    fc_func_if.master  bus
);
    localparam int AW = $clog2(FIFO_LENGTH);
    localparam int SW = OBUF_DATA_SIZE + $clog2(V_CIM_TILES) + 1;
    localparam int OW = NUM_CHANNELS*DATA_SIZE;
    localparam logic [AW-1:0] LAST = AW'(FIFO_LENGTH-1);
`ifdef FC_FUNC_RELU_EN
    localparam logic signed [SW-1:0] HI = SW'((2**DATA_SIZE)-1);
    localparam logic signed [SW-1:0] LO = '0;
`else
    localparam logic signed [SW-1:0] HI = SW'((2**(DATA_SIZE-1))-1);
    localparam logic signed [SW-1:0] LO = SW'(-(2**(DATA_SIZE-1)));
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_START
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          drn_q, drn_d;
    logic          vld_q;
    logic [OW-1:0] data_q, data_d;
    logic [OW-1:0] q_d;
    logic          ready;
    logic          nstart;

    logic signed [SW-1:0]     acc;
    logic signed [SW-1:0]     shf;
    logic [OBUF_DATA_SIZE-1:0] part;
    logic [DATA_SIZE-1:0]      el;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        drn_d   = 1'b0;
        ready   = 1'b0;
        nstart  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready  = !bus.i_next_busy;
                addr_d = '0;
                if (bus.i_start && ready)
                    state_d = S_READ;
            end
            S_READ: begin
                rd_d = 1'b1;
                if (addr_q == LAST)
                    state_d = S_DRAIN;
                else
                    addr_d = addr_q + AW'(1);
            end
            // two cycles: last word arrives, then its result is emitted
            S_DRAIN: begin
                drn_d = 1'b1;
                if (drn_q)
                    state_d = S_START;
            end
            S_START: begin
                nstart = 1'b1;
                if (bus.i_next_busy) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        q_d  = '0;
        acc  = '0;
        shf  = '0;
        part = '0;
        el   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            acc = '0;
            for (int t = 0; t < V_CIM_TILES; t++) begin
                part = bus.i_obuf_data[(t*NUM_CHANNELS+c)*OBUF_DATA_SIZE +: OBUF_DATA_SIZE];
                acc  = acc + $signed({{(SW-OBUF_DATA_SIZE){part[OBUF_DATA_SIZE-1]}}, part});
            end
            shf = acc >>> SHIFT;
            if (shf < LO)
                el = LO[DATA_SIZE-1:0];
            else if (shf > HI)
                el = HI[DATA_SIZE-1:0];
            else
                el = shf[DATA_SIZE-1:0];
            q_d[c*DATA_SIZE +: DATA_SIZE] = el;
        end
    end

    assign data_d = rd_q ? q_d : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            drn_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            drn_q   <= drn_d;
            vld_q   <= rd_q;
            data_q  <= data_d;
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_obuf_addr  = addr_q;
    assign bus.o_data       = data_q;
    assign bus.o_valid      = vld_q;
    assign bus.o_next_start = nstart;
endmodule

// File: tb/tb_fc_func.sv
// Bench for fc_func: directed passes against a cycle-timeline model of a pass.
// Model works from accept time and floor-divide/clamp arithmetic on OBUF words.
module tb_fc_func;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fc_func_if bus ();

    fc_func dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [47:0] mem [32];
    logic [7:0]  got [32];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int m_T    = 0;
    int vcnt   = 0;
    bit m_act  = 1'b0;
    bit ns_seen;

    // OBUF: one-cycle read latency
    always @(posedge clk) bus.i_obuf_data <= mem[bus.o_obuf_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] quant(input logic [47:0] w);
        longint a, b, s, f;
        a = longint'($signed(w[23:0]));
        b = longint'($signed(w[47:24]));
        s = a + b;
        if (s >= 0) f = s / 256;
        else        f = -((-s + 255) / 256);
`ifdef FC_FUNC_RELU_EN
        if (f < 0)        f = 0;
        else if (f > 255) f = 255;
`else
        if (f < -128)     f = -128;
        else if (f > 127) f = 127;
`endif
        return f[7:0];
    endfunction

    // Model advances on posedge from the inputs, compares on negedge.
    initial begin
        int n;
        forever begin
            @(posedge clk);
            if (rst) m_act = 1'b0;
            else if (!m_act) begin
                if (bus.i_start && !bus.i_next_busy) begin
                    m_act = 1'b1;
                    m_T   = cyc;
                end
            end else if (cyc - m_T >= 35 && bus.i_next_busy) m_act = 1'b0;
            cyc++;
            @(negedge clk);
            n = cyc - m_T;
            chk("ready", 32'(bus.o_ready), 32'(!m_act && !bus.i_next_busy));
            chk("addr", 32'(bus.o_obuf_addr), !m_act ? 0 : (n <= 32 ? n - 1 : 31));
            chk("valid", 32'(bus.o_valid), 32'(m_act && n >= 3 && n <= 34));
            chk("next_start", 32'(bus.o_next_start), 32'(m_act && n >= 35));
            if (m_act && n >= 3 && n <= 34) begin
                chk("data", 32'(bus.o_data), 32'(quant(mem[n-3])));
                got[n-3] = bus.o_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (bus.o_valid) vcnt++;
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_next_busy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r = {$urandom(), $urandom()};
            mem[i] = r[47:0];
        end
        mem[0] = {24'h000100, 24'h000300};
        mem[1] = {24'h000000, 24'hFFFE00};
        mem[2] = {24'h7FFFFF, 24'h7FFFFF};
        mem[3] = {24'h800000, 24'h800000};
        mem[4] = {24'h000000, 24'h01FF00};

        repeat (3) step();
        chk("rst_ready", 32'(bus.o_ready), 1);
        chk("rst_addr", 32'(bus.o_obuf_addr), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_next_start", 32'(bus.o_next_start), 0);
        rst = 1'b0;
        step();

        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("p1_addr0", 32'(bus.o_obuf_addr), 0);
        step();
        chk("p1_addr1", 32'(bus.o_obuf_addr), 1);
        chk("p1_no_valid_yet", 32'(bus.o_valid), 0);
        step();
        chk("p1_first_valid", 32'(bus.o_valid), 1);
        repeat (32) step();
        chk("p1_ns_rise", 32'(bus.o_next_start), 1);
        chk("p1_addr_hold", 32'(bus.o_obuf_addr), 31);
        repeat (4) step();
        chk("p1_ns_hold", 32'(bus.o_next_start), 1);
`ifdef FC_FUNC_RELU_EN
        chk("lit_sum", 32'(got[0]), 32'h04);
        chk("lit_neg", 32'(got[1]), 32'h00);
        chk("lit_max", 32'(got[2]), 32'hFF);
        chk("lit_min", 32'(got[3]), 32'h00);
        chk("lit_sat", 32'(got[4]), 32'hFF);
`else
        chk("lit_sum", 32'(got[0]), 32'h04);
        chk("lit_neg", 32'(got[1]), 32'hFE);
        chk("lit_max", 32'(got[2]), 32'h7F);
        chk("lit_min", 32'(got[3]), 32'h80);
        chk("lit_sat", 32'(got[4]), 32'h7F);
`endif
        bus.i_next_busy = 1'b1;
        step();
        chk("p1_ns_drop", 32'(bus.o_next_start), 0);
        chk("busy_ready", 32'(bus.o_ready), 0);

        bus.i_start = 1'b1;
        repeat (10) step();
        chk("busy_no_read", 32'(bus.o_obuf_addr), 0);
        chk("busy_ready2", 32'(bus.o_ready), 0);
        bus.i_next_busy = 1'b0;
        step();
        bus.i_start = 1'b0;
        chk("p2_addr0", 32'(bus.o_obuf_addr), 0);
        step();
        chk("p2_addr1", 32'(bus.o_obuf_addr), 1);
        repeat (19) step();
        bus.i_next_busy = 1'b1;
        repeat (14) step();
        chk("p2_ns_pulse", 32'(bus.o_next_start), 1);
        step();
        chk("p2_ns_gone", 32'(bus.o_next_start), 0);
        bus.i_next_busy = 1'b0;

        step();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        repeat (10) step();
        chk("mid_addr10", 32'(bus.o_obuf_addr), 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid", 32'(bus.o_valid), 0);
        chk("mid_data", 32'(bus.o_data), 0);
        chk("mid_addr0", 32'(bus.o_obuf_addr), 0);
        ns_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.o_next_start) ns_seen = 1'b1;
        end
        chk("mid_no_start", 32'(ns_seen), 0);

        vcnt = 0;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("p4_addr0", 32'(bus.o_obuf_addr), 0);
        repeat (34) step();
        chk("p4_ns", 32'(bus.o_next_start), 1);
        chk("p4_vcount", vcnt, 32);
        bus.i_next_busy = 1'b1;
        step();
        bus.i_next_busy = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fc_func.md
# fc_func

Function unit of a fully-connected layer, one per layer. It sits directly downstream of the layer's control FSM and its CIM tiles. On the control FSM's func-start handshake it reads the CIM output buffer, sums the partial results of the layer's vertically stacked tiles, then requantises, activates and saturates each element. The quantised elements stream into the next layer's input buffer, after which the block raises that layer's start.

## Interface

Parameters:
- DATA_SIZE, 8, activation width in bits.
- XBAR_SIZE, 256, crossbar rows/columns.
- OBUF_DATA_SIZE, 2*DATA_SIZE+$clog2(XBAR_SIZE) (=24), width of one signed partial sum.
- NUM_CHANNELS, 1, elements delivered per OBUF word per tile.
- V_CIM_TILES, 2, tiles whose partial sums are added.
- FIFO_LENGTH, 32, OBUF words per pass (XBAR_SIZE/DATA_SIZE/NUM_CHANNELS).
- SHIFT, 8, arithmetic right shift applied after summation.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  func start from layer control; held until accepted.
- o_ready  out  1  can accept a start; this is the control FSM's func-ready input.
- o_obuf_addr  out  $clog2(FIFO_LENGTH)  OBUF read address.
- i_obuf_data  in  V_CIM_TILES*NUM_CHANNELS*OBUF_DATA_SIZE  OBUF read data, one-cycle latency; tile t, channel c at slice (t*NUM_CHANNELS+c)*OBUF_DATA_SIZE.
- o_data  out  NUM_CHANNELS*DATA_SIZE  quantised elements to next ibuf.
- o_valid  out  1  o_data valid; next ibuf shifts in on this.
- i_next_busy  in  1  next layer control busy.
- o_next_start  out  1  start to next layer control.

## Operation

- States: IDLE, READ, DRAIN, START.
- IDLE:
  - o_ready = !i_next_busy (combinational).
  - i_start && o_ready -> READ, address 0.
- READ:
  - o_obuf_addr increments 0..FIFO_LENGTH-1, one per cycle.
  - After issuing address FIFO_LENGTH-1 -> DRAIN.
- DRAIN:
  - Waits until the last element's o_valid has been emitted (2 cycles), then -> START.
- START:
  - o_next_start held 1 until i_next_busy is seen 1, then -> IDLE with o_next_start 0 that cycle.
- Per channel c, arithmetic:
  - Sum V_CIM_TILES signed OBUF_DATA_SIZE values at width OBUF_DATA_SIZE+$clog2(V_CIM_TILES)+1, no overflow.
  - Arithmetic shift right by SHIFT, truncating toward −inf.
  - Activate/saturate per Configuration.
- Pipeline:
  - Data registered on arrival (stage 1).
  - Quantised output registered (stage 2).
  - Exactly FIFO_LENGTH o_valid pulses per pass, in address order, contiguous.
- o_ready is 0 in READ, DRAIN and START. A start arriving then is not accepted and stays pending on i_start.
- Reset, including mid-pass: state IDLE, pipeline valids cleared, partial pass discarded, no o_next_start.

## Timing

- Reset values: o_ready = !i_next_busy (state IDLE), o_obuf_addr 0, o_data 0, o_valid 0, o_next_start 0.
- Accept at cycle T:
  - address 0 at T+1;
  - address k at T+1+k;
  - o_valid for address k at T+3+k;
  - last o_valid at T+2+FIFO_LENGTH;
  - o_next_start first high at T+3+FIFO_LENGTH.
- Simultaneous i_start and i_next_busy in IDLE: not accepted.
- i_next_busy already 1 when START is entered: one-cycle o_next_start pulse, then IDLE.
- o_obuf_addr holds FIFO_LENGTH-1 in DRAIN/START and returns to 0 in IDLE.

## Configuration

- FC_FUNC_RELU_EN defined:
  - ReLU, negatives -> 0.
  - Positives saturate to 2^DATA_SIZE-1.
  - Output unsigned.
- FC_FUNC_RELU_EN undefined:
  - Signed saturation to [−2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - Output two's complement.

## Test plan

- Reset with i_next_busy=0 -> o_ready 1, all other outputs 0. Assert i_start at T -> o_obuf_addr 0..31 on T+1..T+32; o_valid on T+3..T+34; o_next_start from T+35.
- ReLU on, tiles 0x000300 + 0x000100 -> 0x04; tiles −512 + 0 -> 0x00; tiles 0x7FFFFF + 0x7FFFFF -> 0xFF.
- ReLU off, tiles −512 + 0 -> 0xFE (−2); tiles −0x800000 + −0x800000 -> 0x80; 0x01FF00 + 0 -> 0x7F.
- i_next_busy=1 while i_start=1 for 10 cycles -> o_ready 0, no reads. Drop i_next_busy -> accepted next cycle.
- In START hold i_next_busy=0 for 5 cycles -> o_next_start stays 1. Raise i_next_busy -> o_next_start 0 next cycle, o_ready 0 while busy.
- Assert rst at address 10 -> o_valid 0 next cycle, no o_next_start. Restart -> full 32-element pass from address 0.
